simd_issuer: RTL
================

# simd_issuer

Command issuer and completion tracker for a bank of `N_CORES` SIMD cores that share one instruction bus. It accepts operation commands (two source addresses plus an element count) from the host side and picks a free core round-robin. It then enables that core and streams the three-instruction setup sequence (LD src1, LD src2, INFO count) into it. It also watches each core's finish flag, reports completions and releases the finished cores for reuse.

## Interface
Parameters:
- `N_CORES`, 4: number of SIMD cores served.
- `ACK_TIMEOUT`, 16: number of cycles spent in WAIT_ACK before a core is declared faulty.
- `ID_W`, `$clog2(N_CORES)`: width of a core index.

Ports:
- `i_clk`  in  1  the single clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_cmd_valid`  in  1  a command is presented.
- `o_cmd_ready`  out  1  the issuer can accept a command this cycle.
- `i_cmd_src1`  in  addr_t  first operand base address.
- `i_cmd_src2`  in  addr_t  second operand base address.
- `i_cmd_count`  in  addr_t  operation size.
- `o_core_en`  out  N_CORES  one-hot enable pulse to the selected core.
- `o_core_valid`  out  N_CORES  one-hot instruction-valid qualifier.
- `o_instr`  out  instr_t  shared instruction bus (`opcode`, `info`).
- `i_core_ack`  in  N_CORES  per-core ack.
- `i_core_busy`  in  N_CORES  per-core busy.
- `i_core_finish`  in  N_CORES  per-core finished flag.
- `o_core_release`  out  N_CORES  one-cycle pulse that returns a finished core to IDLE.
- `o_done_valid`  out  1  completion report strobe.
- `o_done_id`  out  ID_W  index of the completed core.
- `o_err`  out  1  sticky ack-timeout error.
- `o_idle`  out  1  FSM is in IDLE and no core is allocated.

## Operation
- Per-core state:
  - `alloc[k]` is set when core k is issued to.
  - Core k is free when `!alloc[k] && !i_core_busy[k]`.
- Core selection is round-robin: search starts at `last+1` (mod N) and takes the first free core. `last` resets to N-1, so core 0 is chosen first. `last` updates on every accepted command.
- Issue FSM states are IDLE, ENABLE, SEND_LD1, SEND_LD2, SEND_INFO, WAIT_ACK.
  - IDLE: `o_cmd_ready` = any core free.
    - On `i_cmd_valid && o_cmd_ready`, latch the src1/src2/count fields, latch the selected core as `tgt`, set `alloc[tgt]`, and go to ENABLE.
  - ENABLE: `o_core_en[tgt]` = 1 for this cycle only.
  - SEND_LD1: `o_core_valid[tgt]` = 1, `o_instr` = {INSTR_LD, src1}.
  - SEND_LD2: `o_core_valid[tgt]` = 1, `o_instr` = {INSTR_LD, src2}.
  - SEND_INFO: `o_core_valid[tgt]` = 1, `o_instr` = {INSTR_INFO, count}.
  - The ENABLE and SEND_* states advance unconditionally, one cycle each. The core accepts one instruction per valid cycle in sequence.
  - WAIT_ACK: when `i_core_ack[tgt]` = 1, go to IDLE.
    - If ACK_TIMEOUT cycles pass without ack: set `o_err`, leave `alloc[tgt]` set (the core is quarantined until reset), and go to IDLE.
- Outside the SEND_* states, `o_core_valid` = 0 and `o_instr` = 0.
- Completion path runs every cycle, independent of the issue FSM:
  - Pending = `i_core_finish & alloc`.
  - If any core is pending, select the lowest index j. Drive `o_done_valid` = 1, `o_done_id` = j and `o_core_release[j]` = 1, all registered for one cycle, and clear `alloc[j]`.
  - A finish from an unallocated core is ignored.
- Simultaneous events:
  - Command accept and completion in the same cycle touch different alloc bits, because the accepted core was free. Both updates apply.
  - A core freed by completion becomes selectable from the following cycle.
- Reset at any point:
  - Next cycle the FSM is in IDLE, alloc = 0, `last` = N-1 and `o_err` = 0.
  - All outputs are 0 except `o_idle` = 1. `o_cmd_ready` then follows `i_core_busy`.

## Timing
- All outputs are registered or decoded from registered state. `o_cmd_ready` also depends combinationally on `i_core_busy`.
- Command accepted at cycle t:
  - ENABLE at t+1.
  - LD1 at t+2, LD2 at t+3, INFO at t+4.
  - WAIT_ACK from t+5. Ack is expected at t+5, because the core registers ack after accepting INFO.
  - Earliest next accept is t+6. Throughput is one command per 6 cycles.
- Completion: finish sampled at cycle c gives `o_done_valid`/`o_core_release` at c+1. Multiple finishes drain one per cycle in index order.
- `o_err` stays high until `i_rst`.

## Test plan
- Single issue (N=4, all idle):
  - Stimulus: src1=0x0100, src2=0x0200, count=0x0010 accepted at cycle 0.
  - Required: `o_core_en`=0001 at cycle 1; valid=0001 with {LD,0x0100} at 2, {LD,0x0200} at 3, {INFO,0x0010} at 4; ack at 5; `o_cmd_ready`=1 at 6.
- Round-robin and full:
  - Stimulus: 5 back-to-back commands, no finishes.
  - Required: targets are cores 0,1,2,3; `o_cmd_ready`=0 after the 4th command and the 5th command is held.
- Completion and reuse (continuing the full case):
  - Stimulus: pulse `i_core_finish[2]`.
  - Required: next cycle `o_done_valid`=1, `o_done_id`=2, `o_core_release`=0100. The held 5th command is issued to core 2.
- Simultaneous finish:
  - Stimulus: finish on cores 1 and 3 in the same cycle.
  - Required: done reports id 1 then id 3 in consecutive cycles; `alloc` for both clears.
- Ack timeout:
  - Stimulus: core 0 never acks.
  - Required: after 16 WAIT_ACK cycles `o_err`=1 and the FSM returns to IDLE. Core 0 is never selected again; the next command goes to core 1.
- Reset mid-issue:
  - Stimulus: assert `i_rst` during SEND_LD2.
  - Required: next cycle `o_core_valid`=0, `o_instr`=0, `o_idle`=1, `o_err`=0. The first post-reset command targets core 0.

Source files
------------

// File: rtl/simd_issuer.sv
// simd_issuer: round-robin command issuer and completion tracker for a bank of SIMD cores
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready           command handshake
//   i_cmd_src1/i_cmd_src2/i_cmd_count command fields
//   o_core_en, o_core_valid, o_instr  per-core enable pulse, instruction qualifier, shared bus {opcode, info}
//   i_core_ack/busy/finish            per-core status
//   o_core_release                    one-cycle release pulse to a finished core
//   o_done_valid, o_done_id           completion report
//   o_err                             sticky ack-timeout error
//   o_idle                            FSM idle with no core allocated
module simd_issuer #(
    parameter int N_CORES     = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int ID_W        = $clog2(N_CORES),
    parameter int ADDR_W      = 16,
    parameter int OP_W        = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [ADDR_W-1:0]      i_cmd_src1,
    input  logic [ADDR_W-1:0]      i_cmd_src2,
    input  logic [ADDR_W-1:0]      i_cmd_count,
    output logic [N_CORES-1:0]     o_core_en,
    output logic [N_CORES-1:0]     o_core_valid,
    output logic [OP_W+ADDR_W-1:0] o_instr,
    input  logic [N_CORES-1:0]     i_core_ack,
    input  logic [N_CORES-1:0]     i_core_busy,
    input  logic [N_CORES-1:0]     i_core_finish,
    output logic [N_CORES-1:0]     o_core_release,
    output logic                   o_done_valid,
    output logic [ID_W-1:0]        o_done_id,
    output logic                   o_err,
    output logic                   o_idle
);
    localparam logic [OP_W-1:0] INSTR_LD   = OP_W'(1);
    localparam logic [OP_W-1:0] INSTR_INFO = OP_W'(2);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ENABLE, S_LD1, S_LD2, S_INFO, S_WAIT} state_t;

    state_t              r_state, w_next;
    logic [N_CORES-1:0]  r_alloc, r_release;
    logic [ID_W-1:0]     r_last, r_tgt, r_done_id;
    logic [ADDR_W-1:0]   r_src1, r_src2, r_count;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err, r_done_valid;
    logic [N_CORES-1:0]  w_free, w_pend, w_set, w_clr, w_tgt_oh;
    logic [ID_W-1:0]     w_sel, w_pend_id;
    logic                w_any, w_pend_any, w_accept, w_ack, w_timeout;

    assign w_free    = ~r_alloc & ~i_core_busy;
    assign w_pend    = i_core_finish & r_alloc;
    assign w_tgt_oh  = N_CORES'(1) << r_tgt;
    assign w_ack     = i_core_ack[r_tgt];
    assign w_accept  = (r_state == S_IDLE) && i_cmd_valid && w_any;
    assign w_timeout = (r_state == S_WAIT) && !w_ack && (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign w_set     = w_accept ? N_CORES'(1) << w_sel : '0;
    assign w_clr     = w_pend_any ? N_CORES'(1) << w_pend_id : '0;

    // Descending scans so the last hit wins: nearest core after r_last, lowest pending index.
    always_comb begin
        w_any      = 1'b0;
        w_sel      = '0;
        w_pend_any = 1'b0;
        w_pend_id  = '0;
        for (int i = N_CORES; i >= 1; i--) begin
            if (w_free[(int'(r_last) + i) % N_CORES]) begin
                w_any = 1'b1;
                w_sel = ID_W'((int'(r_last) + i) % N_CORES);
            end
        end
        for (int j = N_CORES - 1; j >= 0; j--) begin
            if (w_pend[j]) begin
                w_pend_any = 1'b1;
                w_pend_id  = ID_W'(j);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        o_cmd_ready  = (r_state == S_IDLE) && w_any;
        o_core_en    = (r_state == S_ENABLE) ? w_tgt_oh : '0;
        o_core_valid = (r_state == S_LD1 || r_state == S_LD2 || r_state == S_INFO) ? w_tgt_oh : '0;
        o_instr      = (r_state == S_LD1)  ? {INSTR_LD, r_src1} :
                       (r_state == S_LD2)  ? {INSTR_LD, r_src2} :
                       (r_state == S_INFO) ? {INSTR_INFO, r_count} : '0;
        case (r_state)
            S_IDLE:   w_next = w_accept ? S_ENABLE : S_IDLE;
            S_ENABLE: w_next = S_LD1;
            S_LD1:    w_next = S_LD2;
            S_LD2:    w_next = S_INFO;
            S_INFO:   w_next = S_WAIT;
            S_WAIT:   w_next = (w_ack || w_timeout) ? S_IDLE : S_WAIT;
            default:  w_next = S_IDLE;
        endcase
    end

    // A timed-out core keeps its alloc bit, quarantining it until reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_alloc      <= '0;
            r_last       <= ID_W'(N_CORES - 1);
            r_tgt        <= '0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_count      <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_id    <= '0;
            r_release    <= '0;
        end else begin
            r_alloc      <= (r_alloc | w_set) & ~w_clr;
            r_cnt        <= (r_state == S_WAIT) ? r_cnt + CNT_W'(1) : '0;
            r_err        <= r_err | w_timeout;
            r_done_valid <= w_pend_any;
            r_done_id    <= w_pend_id;
            r_release    <= w_clr;
            if (w_accept) begin
                r_tgt   <= w_sel;
                r_last  <= w_sel;
                r_src1  <= i_cmd_src1;
                r_src2  <= i_cmd_src2;
                r_count <= i_cmd_count;
            end
        end
    end

    assign o_core_release = r_release;
    assign o_done_valid   = r_done_valid;
    assign o_done_id      = r_done_id;
    assign o_err          = r_err;
    assign o_idle         = (r_state == S_IDLE) && (r_alloc == '0);
endmodule
